// File: rtl/dds_serial_writer_if.sv
// Sequencer-to-writer link: frame request, byte stream handshake and status.
interface dds_serial_writer_if;
    logic       start;
    logic [4:0] nbytes;
    logic       do_reset;
    logic       do_update;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       done;

    // Sequencer side
    modport master (
        output start, nbytes, do_reset, do_update, byte_data, byte_valid,
        input  byte_ready, busy, done
    );

    // Serial writer side
    modport slave (
        input  start, nbytes, do_reset, do_update, byte_data, byte_valid,
        output byte_ready, busy, done
    );
endinterface

// File: rtl/dds_serial_writer.sv
// DDS serial-port write engine: shifts a frame of bytes MSB-first on SDIO/SCLK
// under CSB, optionally bracketed by IO_RESET and IO_UPDATE pulses.
// All pin outputs come straight from flops so the DDS never sees decode glitches.
module dds_serial_writer #(
    parameter int unsigned SCLK_HALF        = 3,
    parameter int unsigned IO_RESET_CYCLES  = 50,
    parameter int unsigned IO_UPDATE_CYCLES = 50,
    parameter int unsigned MAX_BYTES        = 31
) (
    input  logic                 fifty_MHz_intclk,
    input  logic                 reset,
    dds_serial_writer_if.slave   bus,
    output logic                 SDIO,
    output logic                 SCLK,
    output logic                 CSB,
    output logic                 IO_RESET,
    output logic                 IO_UPDATE
);

    // One shared counter times SCLK half-periods and both pulse widths.
    localparam int unsigned CntMax0 = (IO_RESET_CYCLES > IO_UPDATE_CYCLES) ?
                                      IO_RESET_CYCLES : IO_UPDATE_CYCLES;
    localparam int unsigned CntMax  = ((CntMax0 > SCLK_HALF) ? CntMax0 : SCLK_HALF) - 1;
    localparam int unsigned CntW    = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

    localparam logic [CntW-1:0] HalfLast = CntW'(SCLK_HALF - 1);
    localparam logic [CntW-1:0] RstLast  = CntW'(IO_RESET_CYCLES - 1);
    localparam logic [CntW-1:0] UpdLast  = CntW'(IO_UPDATE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRstPulse,
        StLoad,
        StShift,
        StCsHold,
        StUpdPulse,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [4:0]      left_q, left_d;
    logic            upd_q, upd_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            sdio_q, sdio_d;
    logic            sclk_q, sclk_d;
    logic            csb_q, csb_d;
    logic            io_reset_q, io_reset_d;
    logic            io_update_q, io_update_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [4:0]      nbytes_clamped;

    // Oversized requests are shortened to the largest legal frame.
    always_comb begin
        nbytes_clamped = bus.nbytes;
        if (32'(bus.nbytes) > MAX_BYTES) begin
            nbytes_clamped = 5'(MAX_BYTES);
        end
    end

    // Next state plus the pin values that go with it (registered below).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        left_d      = left_q;
        upd_d       = upd_q;
        shreg_d     = shreg_q;
        sdio_d      = sdio_q;
        sclk_d      = sclk_q;
        csb_d       = csb_q;
        io_reset_d  = io_reset_q;
        io_update_d = io_update_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.nbytes == 5'd0) begin
                        // Empty frame: report completion without touching the pins.
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        left_d = nbytes_clamped;
                        upd_d  = bus.do_update;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                        if (bus.do_reset) begin
                            state_d    = StRstPulse;
                            io_reset_d = 1'b1;
                        end else begin
                            state_d = StLoad;
                            csb_d   = 1'b0;
                            ready_d = 1'b1;
                        end
                    end
                end
            end

            StRstPulse: begin
                if (cnt_q == RstLast) begin
                    // IO_RESET drops on the same edge CSB falls, so they never overlap.
                    io_reset_d = 1'b0;
                    state_d    = StLoad;
                    csb_d      = 1'b0;
                    ready_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StLoad: begin
                if (bus.byte_valid) begin
                    shreg_d = bus.byte_data;
                    sdio_d  = bus.byte_data[7];
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = StShift;
                end
            end

            StShift: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of high phase: SCLK falls and SDIO moves on together.
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            left_d = left_q - 5'd1;
                            if (left_q == 5'd1) begin
                                state_d = StCsHold;
                            end else begin
                                state_d = StLoad;
                                ready_d = 1'b1;
                            end
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shreg_d = shreg_q << 1;
                            sdio_d  = shreg_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StCsHold: begin
                if (cnt_q == HalfLast) begin
                    csb_d  = 1'b1;
                    sdio_d = 1'b0;
                    cnt_d  = '0;
                    if (upd_q) begin
                        state_d     = StUpdPulse;
                        io_update_d = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StUpdPulse: begin
                if (cnt_q == UpdLast) begin
                    io_update_d = 1'b0;
                    state_d     = StDone;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StDone: begin
                // Any start seen here is dropped on purpose.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, datapath and pin registers; reset parks every pin in its idle level.
    always_ff @(posedge fifty_MHz_intclk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            left_q      <= 5'd0;
            upd_q       <= 1'b0;
            shreg_q     <= 8'd0;
            sdio_q      <= 1'b0;
            sclk_q      <= 1'b0;
            csb_q       <= 1'b1;
            io_reset_q  <= 1'b0;
            io_update_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            left_q      <= left_d;
            upd_q       <= upd_d;
            shreg_q     <= shreg_d;
            sdio_q      <= sdio_d;
            sclk_q      <= sclk_d;
            csb_q       <= csb_d;
            io_reset_q  <= io_reset_d;
            io_update_q <= io_update_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign SDIO           = sdio_q;
    assign SCLK           = sclk_q;
    assign CSB            = csb_q;
    assign IO_RESET       = io_reset_q;
    assign IO_UPDATE      = io_update_q;
    assign bus.byte_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_dds_serial_writer.sv
// Directed bench for dds_serial_writer with SCLK_HALF=3 and 50-cycle pulses.
module tb_dds_serial_writer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sdio, sclk, csb, io_reset, io_update;

    dds_serial_writer_if bus ();

    dds_serial_writer #(
        .SCLK_HALF        (3),
        .IO_RESET_CYCLES  (50),
        .IO_UPDATE_CYCLES (50),
        .MAX_BYTES        (31)
    ) dut (
        .fifty_MHz_intclk (clk),
        .reset            (reset),
        .bus              (bus),
        .SDIO             (sdio),
        .SCLK             (sclk),
        .CSB              (csb),
        .IO_RESET         (io_reset),
        .IO_UPDATE        (io_update)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Pin monitor, sampled 1 time unit after each rising edge.
    int   cyc = 0;
    int   csb_low_total = 0, rise_total = 0, done_total = 0;
    int   rst_total = 0, upd_total = 0, excl_bad = 0, sclk_bad = 0;
    int   csb_fall_cyc = -1, csb_rise_cyc = -1, rst_fall_cyc = -1;
    int   upd_rise_cyc = -1, upd_fall_cyc = -1, done_cyc = -1;
    logic csb_prev = 1'b1, sclk_prev = 1'b0, rst_prev = 1'b0, upd_prev = 1'b0;
    logic bits[$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (csb === 1'b0) csb_low_total++;
        if (csb === 1'b0 && csb_prev) csb_fall_cyc = cyc;
        if (csb === 1'b1 && !csb_prev) csb_rise_cyc = cyc;
        if (sclk === 1'b1 && !sclk_prev) begin
            rise_total++;
            bits.push_back(sdio);
        end
        if (sclk === 1'b1 && csb !== 1'b0) sclk_bad++;
        if (bus.done === 1'b1) begin
            done_total++;
            done_cyc = cyc;
        end
        if (io_reset === 1'b1) rst_total++;
        if (io_reset === 1'b0 && rst_prev) rst_fall_cyc = cyc;
        if (io_update === 1'b1) upd_total++;
        if (io_update === 1'b1 && !upd_prev) upd_rise_cyc = cyc;
        if (io_update === 1'b0 && upd_prev) upd_fall_cyc = cyc;
        if ((io_reset === 1'b1 || io_update === 1'b1) && csb === 1'b0) excl_bad++;
        csb_prev  = csb;
        sclk_prev = sclk;
        rst_prev  = io_reset;
        upd_prev  = io_update;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] fb[0:31];
    int csb0, rise0, bit0, done0, rst0, upd0, start_cyc, stall_bad;

    task automatic snapshot();
        csb0  = csb_low_total;
        rise0 = rise_total;
        bit0  = bits.size();
        done0 = done_total;
        rst0  = rst_total;
        upd0  = upd_total;
    endtask

    task automatic pulse_start(input int n, input logic dr, input logic du);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.nbytes    = 5'(n);
        bus.do_reset  = dr;
        bus.do_update = du;
        start_cyc     = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic feed_byte(input logic [7:0] b);
        int t = 0;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check_val("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_total == done0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) check_val("done_timeout", 32'(t), 32'd0);
    endtask

    task automatic check_bytes(input string tag, input int n);
        logic [7:0] g;
        if (bits.size() < bit0 + 8 * n) begin
            check_val({tag, "_bitcount"}, 32'(bits.size() - bit0), 32'(8 * n));
            return;
        end
        for (int i = 0; i < n; i++) begin
            g = 8'd0;
            for (int j = 0; j < 8; j++) g = {g[6:0], bits[bit0 + i * 8 + j]};
            check_val($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(fb[i]));
        end
    endtask

    task automatic run_frame(input int n, input logic dr, input logic du,
                             input int stall_at);
        int t;
        snapshot();
        stall_bad = 0;
        pulse_start(n, dr, du);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                bus.byte_valid = 1'b0;
                t = 0;
                while (bus.byte_ready !== 1'b1 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                repeat (20) begin
                    if (csb !== 1'b0 || sclk !== 1'b0) stall_bad++;
                    @(negedge clk);
                end
            end
            feed_byte(fb[i]);
        end
        bus.byte_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] init_img[0:28];

    initial begin
        bus.start      = 1'b0;
        bus.nbytes     = 5'd0;
        bus.do_reset   = 1'b0;
        bus.do_update  = 1'b0;
        bus.byte_data  = 8'd0;
        bus.byte_valid = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_csb", 32'(csb), 32'd1);
        check_val("rst_sclk", 32'(sclk), 32'd0);
        check_val("rst_sdio", 32'(sdio), 32'd0);
        check_val("rst_ioreset", 32'(io_reset), 32'd0);
        check_val("rst_ioupdate", 32'(io_update), 32'd0);
        check_val("rst_ready", 32'(bus.byte_ready), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: 1*(1+48)+3 = 52 clocks of CSB low
        fb[0] = 8'hA5;
        run_frame(1, 1'b0, 1'b0, -1);
        check_val("t1_csb_low", 32'(csb_low_total - csb0), 32'd52);
        check_val("t1_rises", 32'(rise_total - rise0), 32'd8);
        check_bytes("t1", 1);
        check_val("t1_csb_fall", 32'(csb_fall_cyc - start_cyc), 32'd1);
        check_val("t1_done_after_csb", 32'(done_cyc), 32'(csb_rise_cyc));
        check_val("t1_done_cnt", 32'(done_total - done0), 32'd1);
        check_val("t1_ioreset", 32'(rst_total - rst0), 32'd0);
        check_val("t1_ioupdate", 32'(upd_total - upd0), 32'd0);

        // Full 232-bit init image with reset and update pulses
        init_img = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h00, 8'h48,
                     8'h00, 8'h20, 8'h02, 8'h35, 8'h3F, 8'hC1, 8'hC8, 8'h03,
                     8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 29; i++) fb[i] = init_img[i];
        run_frame(29, 1'b1, 1'b1, -1);
        check_val("t2_ioreset_len", 32'(rst_total - rst0), 32'd50);
        check_val("t2_reset_then_csb", 32'(rst_fall_cyc), 32'(csb_fall_cyc));
        check_val("t2_csb_fall", 32'(csb_fall_cyc - start_cyc), 32'd51);
        check_val("t2_rises", 32'(rise_total - rise0), 32'd232);
        check_val("t2_csb_low", 32'(csb_low_total - csb0), 32'd1424);
        check_bytes("t2", 29);
        check_val("t2_ioupdate_len", 32'(upd_total - upd0), 32'd50);
        check_val("t2_update_after_csb", 32'(upd_rise_cyc), 32'(csb_rise_cyc));
        check_val("t2_done_after_upd", 32'(done_cyc), 32'(upd_fall_cyc));

        // Stall 20 extra LOAD cycles before byte 2: 3*49+3+20 = 170
        fb[0] = 8'h3C;
        fb[1] = 8'h96;
        fb[2] = 8'h5A;
        run_frame(3, 1'b0, 1'b0, 2);
        check_val("t3_stall_pins", 32'(stall_bad), 32'd0);
        check_val("t3_rises", 32'(rise_total - rise0), 32'd24);
        check_val("t3_csb_low", 32'(csb_low_total - csb0), 32'd170);
        check_bytes("t3", 3);

        // Reset during byte 1 of a 10-byte sweep
        for (int i = 0; i < 10; i++) fb[i] = 8'(8'hFF - i);
        snapshot();
        pulse_start(10, 1'b0, 1'b0);
        feed_byte(fb[0]);
        feed_byte(fb[1]);
        begin
            int t = 0;
            while (rise_total - rise0 < 12 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) check_val("t4_rise_timeout", 32'(t), 32'd0);
        end
        check_val("t4_sdio_pre", 32'(sdio), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t4_csb", 32'(csb), 32'd1);
        check_val("t4_sclk", 32'(sclk), 32'd0);
        check_val("t4_sdio", 32'(sdio), 32'd0);
        check_val("t4_busy", 32'(bus.busy), 32'd0);
        check_val("t4_ready", 32'(bus.byte_ready), 32'd0);
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (40) @(negedge clk);
        check_val("t4_no_done", 32'(done_total - done0), 32'd0);
        check_val("t4_no_more_rises", 32'(rise_total - rise0), 32'd12);
        run_frame(10, 1'b0, 1'b0, -1);
        check_val("t4_clean_rises", 32'(rise_total - rise0), 32'd80);
        check_val("t4_clean_csb_low", 32'(csb_low_total - csb0), 32'd493);
        check_val("t4_clean_done", 32'(done_total - done0), 32'd1);
        check_bytes("t4", 10);

        // nbytes = 0: done on the next cycle, no CSB activity
        snapshot();
        pulse_start(0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_val("t5_done_cyc", 32'(done_cyc - start_cyc), 32'd1);
        check_val("t5_done_cnt", 32'(done_total - done0), 32'd1);
        check_val("t5_csb_low", 32'(csb_low_total - csb0), 32'd0);

        // Start while busy is dropped: 2*49+3 = 101
        fb[0] = 8'hC3;
        fb[1] = 8'h3C;
        snapshot();
        pulse_start(2, 1'b0, 1'b0);
        feed_byte(fb[0]);
        check_val("t6_busy", 32'(bus.busy), 32'd1);
        bus.start  = 1'b1;
        bus.nbytes = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        feed_byte(fb[1]);
        bus.byte_valid = 1'b0;
        wait_done();
        repeat (80) @(negedge clk);
        check_val("t6_rises", 32'(rise_total - rise0), 32'd16);
        check_val("t6_csb_low", 32'(csb_low_total - csb0), 32'd101);
        check_val("t6_done_cnt", 32'(done_total - done0), 32'd1);
        check_bytes("t6", 2);

        // Whole-run invariants
        check_val("excl_pulse_csb", 32'(excl_bad), 32'd0);
        check_val("sclk_outside_csb", 32'(sclk_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
